msu_audio_fill: RTL and testbench

Byte-stream loader that feeds the 2 KiB stereo sample buffer in front of the audio DAC stage. It accepts 8-bit sample bytes over a valid/ready handshake and writes them into the buffer through the DAC's program port (`pgm_address`, `pgm_data`, `we` active-low). It tracks the DAC's half-buffer status bit to refill whichever half is not being played, and drives the DAC `play` input. On end of stream it zero-pads the current half and stops playback once that half has been consumed.

---
 rtl/msu_audio_fill_pkg.sv | 25 ++
 rtl/msu_audio_fill.sv | 197 +++++++++++++++++++
 tb/tb_msu_audio_fill.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/msu_audio_fill_pkg.sv
// Shared buffer geometry and loader state encoding for the MSU audio path.
// The DAC stage sizes its sample RAM from the same constants.
package msu_audio_fill_pkg;

  localparam int BUF_BYTES  = 2048;
  localparam int HALF_BYTES = BUF_BYTES / 2;
  localparam int ADDR_W     = $clog2(BUF_BYTES);
  localparam int OFF_W      = $clog2(HALF_BYTES);

  // One-hot loader states; IDLE owns the top bit.
  typedef enum logic [5:0] {
    S_IDLE  = 6'b100000,
    S_PRIME = 6'b010000,
    S_WAIT  = 6'b001000,
    S_FILL  = 6'b000100,
    S_PAD   = 6'b000010,
    S_DRAIN = 6'b000001
  } fill_state_e;

  // True when the pointer sits on the last byte of its half.
  function automatic logic half_end(input logic [ADDR_W-1:0] ptr);
    return ptr[OFF_W-1:0] == {OFF_W{1'b1}};
  endfunction

endpackage

// File: rtl/msu_audio_fill.sv
// Streams sample bytes into the DAC double buffer, refilling whichever half
// the DAC is not playing, and zero-pads plus drains at end of stream.
module msu_audio_fill
  import msu_audio_fill_pkg::*;
(
  input  logic              clkin,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [7:0]        src_data,
  input  logic              src_valid,
  input  logic              src_last,
  output logic              src_ready,
  input  logic              dac_status,
  output logic [ADDR_W-1:0] pgm_address,
  output logic [7:0]        pgm_data,
  output logic              we,
  output logic              play,
  output logic              busy,
  output logic              underrun
);

  fill_state_e       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              stat_q, stat_d;
  logic              last_half_q, last_half_d;
  logic              from_prime_q, from_prime_d;
  logic              play_pend_q, play_pend_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              we_n_q, we_n_d;
  logic              play_q, play_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              underrun_q, underrun_d;

  logic              accept;
  logic              stat_edge;

  // Next-state and next-output computation for the loader FSM.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    stat_d       = dac_status;
    last_half_d  = last_half_q;
    from_prime_d = from_prime_q;
    play_pend_d  = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;
    we_n_d       = 1'b1;
    play_d       = play_q;
    ready_d      = ready_q;
    underrun_d   = underrun_q;

    accept    = src_valid & ready_q;
    stat_edge = dac_status ^ stat_q;

    if (stop) begin
      state_d = S_IDLE;
      play_d  = 1'b0;
      ready_d = 1'b0;
    end else if (start) begin
      state_d      = S_PRIME;
      ptr_d        = {ADDR_W{1'b0}};
      underrun_d   = 1'b0;
      play_d       = 1'b0;
      ready_d      = 1'b1;
      from_prime_d = 1'b0;
    end else begin
      // play is raised one cycle after the strobe that completes the prime.
      play_d = play_q | play_pend_q;
      case (state_q)
        S_IDLE: begin
          ready_d = 1'b0;
        end

        S_PRIME, S_FILL: begin
          if ((state_q == S_FILL) && stat_edge) begin
            underrun_d = 1'b1;
          end else begin
            underrun_d = underrun_q;
          end
          if (accept) begin
            addr_d = ptr_q;
            data_d = src_data;
            we_n_d = 1'b0;
            ptr_d  = ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            if (src_last) begin
              last_half_d = ptr_q[ADDR_W-1];
              ready_d     = 1'b0;
              if (half_end(ptr_q)) begin
                state_d     = S_DRAIN;
                play_pend_d = (state_q == S_PRIME);
              end else begin
                state_d      = S_PAD;
                from_prime_d = (state_q == S_PRIME);
              end
            end else if (half_end(ptr_q) &&
                         ((state_q == S_FILL) || ptr_q[ADDR_W-1])) begin
              ready_d     = 1'b0;
              state_d     = S_WAIT;
              play_pend_d = (state_q == S_PRIME);
            end else begin
              ready_d = 1'b1;
            end
          end else begin
            ready_d = 1'b1;
          end
        end

        S_WAIT: begin
          // The DAC moved on, so the half it was reading is free to refill.
          if (stat_edge) begin
            ptr_d   = {stat_q, {OFF_W{1'b0}}};
            state_d = S_FILL;
            ready_d = 1'b1;
          end else begin
            ready_d = 1'b0;
          end
        end

        S_PAD: begin
          addr_d = ptr_q;
          data_d = 8'h00;
          we_n_d = 1'b0;
          ptr_d  = ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          if (half_end(ptr_q)) begin
            state_d     = S_DRAIN;
            play_pend_d = from_prime_q;
          end else begin
            state_d = S_PAD;
          end
        end

        S_DRAIN: begin
          if ((stat_q == last_half_q) && (dac_status != last_half_q)) begin
            play_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            state_d = S_DRAIN;
          end
        end

        default: begin
          state_d = S_IDLE;
          play_d  = 1'b0;
          ready_d = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // State, pointer and registered-output update.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= {ADDR_W{1'b0}};
      stat_q       <= dac_status;
      last_half_q  <= 1'b0;
      from_prime_q <= 1'b0;
      play_pend_q  <= 1'b0;
      addr_q       <= {ADDR_W{1'b0}};
      data_q       <= 8'h00;
      we_n_q       <= 1'b1;
      play_q       <= 1'b0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      stat_q       <= stat_d;
      last_half_q  <= last_half_d;
      from_prime_q <= from_prime_d;
      play_pend_q  <= play_pend_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      we_n_q       <= we_n_d;
      play_q       <= play_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      underrun_q   <= underrun_d;
    end
  end

  assign pgm_address = addr_q;
  assign pgm_data    = data_q;
  assign we          = we_n_q;
  assign play        = play_q;
  assign src_ready   = ready_q;
  assign busy        = busy_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_msu_audio_fill.sv
// Directed bench for msu_audio_fill: prime, refill, underrun, end of stream,
// short stream, stop and reset behaviour.
module tb_msu_audio_fill;

  logic        clkin = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [7:0]  src_data = 8'h00;
  logic        src_valid = 1'b0;
  logic        src_last = 1'b0;
  logic        src_ready;
  logic        dac_status = 1'b0;
  logic [10:0] pgm_address;
  logic [7:0]  pgm_data;
  logic        we;
  logic        play;
  logic        busy;
  logic        underrun;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    logic [10:0] addr;
    logic [7:0]  data;
    int          cyc;
  } wr_t;
  wr_t wr_q[$];

  msu_audio_fill dut (
    .clkin       (clkin),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .src_data    (src_data),
    .src_valid   (src_valid),
    .src_last    (src_last),
    .src_ready   (src_ready),
    .dac_status  (dac_status),
    .pgm_address (pgm_address),
    .pgm_data    (pgm_data),
    .we          (we),
    .play        (play),
    .busy        (busy),
    .underrun    (underrun)
  );

  always #5 clkin = ~clkin;

  always @(posedge clkin) cyc <= cyc + 1;

  // Capture every buffer write strobe with its cycle number.
  always @(negedge clkin) begin
    if (we === 1'b0) wr_q.push_back('{pgm_address, pgm_data, cyc});
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int seed, input int i);
    return 8'((i * 13 + seed * 29) ^ (i >> 3));
  endfunction

  // Drives n bytes with src_valid held; returns after the final byte is presented to an open ready.
  task automatic send_bytes(input int n, input int seed, input int first, input bit with_last);
    int k = 0;
    int waits = 0;
    while (k < n && waits < 4000) begin
      @(negedge clkin);
      src_valid = 1'b1;
      src_data  = pat(seed, first + k);
      src_last  = with_last && (k == n - 1);
      if (src_ready === 1'b1) k++;
      else waits++;
    end
    check_eq("send_done", 32'(k), 32'(n));
  endtask

  task automatic idle_src();
    src_valid = 1'b0;
    src_last  = 1'b0;
  endtask

  task automatic wait_strobe(input string tag, input logic [10:0] addr, input int budget);
    int t = 0;
    bit found = 1'b0;
    while (!found && t < budget) begin
      @(negedge clkin);
      if (we === 1'b0 && pgm_address == addr) found = 1'b1;
      t++;
    end
    check_eq(tag, 32'(found), 32'd1);
  endtask

  task automatic check_burst(input string tag, input int base, input int n_data,
                             input int seed, input int n_pad);
    int bad = 0;
    int gaps = 0;
    logic [7:0] exp_d;
    check_eq({tag, "_count"}, 32'(wr_q.size()), 32'(n_data + n_pad));
    for (int i = 0; i < wr_q.size() && i < n_data + n_pad; i++) begin
      exp_d = (i < n_data) ? pat(seed, i) : 8'h00;
      if (wr_q[i].addr != 11'(base + i) || wr_q[i].data != exp_d) bad++;
      if (i > 0 && wr_q[i].cyc != wr_q[i-1].cyc + 1) gaps++;
    end
    check_eq({tag, "_content"}, 32'(bad), 32'd0);
    check_eq({tag, "_gaps"}, 32'(gaps), 32'd0);
    wr_q.delete();
  endtask

  task automatic pulse_start();
    @(negedge clkin);
    start = 1'b1;
    @(negedge clkin);
    start = 1'b0;
  endtask

  task automatic toggle_dac(input logic v);
    @(negedge clkin);
    dac_status = v;
  endtask

  initial begin
    repeat (3) @(negedge clkin);
    reset = 1'b0;
    @(negedge clkin);
    check_eq("rst_addr", 32'(pgm_address), 32'd0);
    check_eq("rst_data", 32'(pgm_data), 32'd0);
    check_eq("rst_we", 32'(we), 32'd1);
    check_eq("rst_play", 32'(play), 32'd0);
    check_eq("rst_ready", 32'(src_ready), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_underrun", 32'(underrun), 32'd0);

    // Prime the whole buffer.
    wr_q.delete();
    pulse_start();
    check_eq("prime_ready", 32'(src_ready), 32'd1);
    check_eq("prime_busy", 32'(busy), 32'd1);
    send_bytes(2048, 1, 0, 1'b0);
    @(negedge clkin);
    idle_src();
    check_eq("prime_last_we", 32'(we), 32'd0);
    check_eq("prime_last_addr", 32'(pgm_address), 32'h7FF);
    check_eq("prime_play_early", 32'(play), 32'd0);
    check_eq("prime_ready_fall", 32'(src_ready), 32'd0);
    @(negedge clkin);
    check_eq("prime_play", 32'(play), 32'd1);
    #1 check_burst("prime", 0, 2048, 1, 0);

    // Refill half 0, then half 1.
    toggle_dac(1'b1);
    @(negedge clkin);
    check_eq("fill0_ready_rise", 32'(src_ready), 32'd1);
    send_bytes(1024, 2, 0, 1'b0);
    @(negedge clkin);
    idle_src();
    @(negedge clkin);
    check_eq("fill0_ready_low", 32'(src_ready), 32'd0);
    #1 check_burst("fill0", 0, 1024, 2, 0);
    toggle_dac(1'b0);
    send_bytes(1024, 3, 0, 1'b0);
    @(negedge clkin);
    idle_src();
    @(negedge clkin);
    check_eq("fill1_underrun", 32'(underrun), 32'd0);
    check_eq("fill1_play", 32'(play), 32'd1);
    #1 check_burst("fill1", 1024, 1024, 3, 0);

    // DAC wraps into half 0 while it is only 100 bytes into its refill.
    toggle_dac(1'b1);
    send_bytes(100, 4, 0, 1'b0);
    dac_status = 1'b0;
    send_bytes(924, 4, 100, 1'b0);
    @(negedge clkin);
    idle_src();
    @(negedge clkin);
    check_eq("urun_flag", 32'(underrun), 32'd1);
    #1 check_burst("urun_fill", 0, 1024, 4, 0);
    toggle_dac(1'b1);
    send_bytes(1024, 5, 0, 1'b0);
    @(negedge clkin);
    idle_src();
    @(negedge clkin);
    check_eq("urun_sticky", 32'(underrun), 32'd1);
    #1 check_burst("fill_h0", 0, 1024, 5, 0);

    // End of stream at 0x410, pad to 0x7FF, then drain.
    toggle_dac(1'b0);
    send_bytes(17, 6, 0, 1'b1);
    @(negedge clkin);
    idle_src();
    check_eq("eos_ready_fall", 32'(src_ready), 32'd0);
    wait_strobe("eos_pad_end", 11'h7FF, 1100);
    #1 check_burst("eos", 1024, 17, 6, 1007);
    repeat (2) @(negedge clkin);
    check_eq("eos_play_hold", 32'(play), 32'd1);
    toggle_dac(1'b1);
    repeat (2) @(negedge clkin);
    check_eq("eos_play_first_edge", 32'(play), 32'd1);
    check_eq("eos_busy_first_edge", 32'(busy), 32'd1);
    toggle_dac(1'b0);
    @(negedge clkin);
    check_eq("eos_play_off", 32'(play), 32'd0);
    check_eq("eos_busy_off", 32'(busy), 32'd0);
    check_eq("eos_underrun_kept", 32'(underrun), 32'd1);

    // Short stream ending at address 5 during prime.
    wr_q.delete();
    pulse_start();
    check_eq("short_underrun_clr", 32'(underrun), 32'd0);
    send_bytes(6, 7, 0, 1'b1);
    @(negedge clkin);
    idle_src();
    wait_strobe("short_pad_end", 11'h3FF, 1100);
    check_eq("short_play_early", 32'(play), 32'd0);
    @(negedge clkin);
    check_eq("short_play", 32'(play), 32'd1);
    #1 check_burst("short", 0, 6, 7, 1018);
    toggle_dac(1'b1);
    @(negedge clkin);
    check_eq("short_play_off", 32'(play), 32'd0);
    check_eq("short_busy_off", 32'(busy), 32'd0);

    // stop together with start mid-FILL.
    pulse_start();
    send_bytes(2048, 8, 0, 1'b0);
    @(negedge clkin);
    idle_src();
    repeat (2) @(negedge clkin);
    toggle_dac(1'b0);
    send_bytes(50, 9, 0, 1'b0);
    @(negedge clkin);
    stop  = 1'b1;
    start = 1'b1;
    @(negedge clkin);
    stop  = 1'b0;
    start = 1'b0;
    idle_src();
    check_eq("stop_play", 32'(play), 32'd0);
    check_eq("stop_busy", 32'(busy), 32'd0);
    check_eq("stop_ready", 32'(src_ready), 32'd0);
    check_eq("stop_we", 32'(we), 32'd1);
    #1 wr_q.delete();
    repeat (10) @(negedge clkin);
    #1 check_eq("stop_no_strobe", 32'(wr_q.size()), 32'd0);

    // reset in the middle of a prime.
    pulse_start();
    send_bytes(300, 10, 0, 1'b0);
    @(negedge clkin);
    reset = 1'b1;
    @(negedge clkin);
    reset = 1'b0;
    idle_src();
    check_eq("mrst_addr", 32'(pgm_address), 32'd0);
    check_eq("mrst_data", 32'(pgm_data), 32'd0);
    check_eq("mrst_we", 32'(we), 32'd1);
    check_eq("mrst_play", 32'(play), 32'd0);
    check_eq("mrst_ready", 32'(src_ready), 32'd0);
    check_eq("mrst_busy", 32'(busy), 32'd0);
    check_eq("mrst_underrun", 32'(underrun), 32'd0);
    #1 wr_q.delete();
    repeat (5) @(negedge clkin);
    #1 check_eq("mrst_no_strobe", 32'(wr_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
